// File: rtl/posit_pkg.sv
// Shared posit definitions: type codes and derived field widths, so the
// decoders, this multiplier and the encoder all size their fields the same way.
package posit_pkg;

    localparam logic [1:0] POSIT_ZERO  = 2'b00;
    localparam logic [1:0] POSIT_VALID = 2'b01;
    localparam logic [1:0] POSIT_NAR   = 2'b10;

    // Signed regime width: enough for k in [-(n-1), n-1]
    function automatic int reg_w(input int in_s);
        return $clog2(in_s) + 1;
    endfunction

    // Fraction bits left after sign, two minimum regime bits and the exponent
    function automatic int mts_w(input int in_s, input int exp_s);
        return in_s - 3 - exp_s;
    endfunction

    // Product scale width: sum of two scales plus the normalization carry
    function automatic int sco_w(input int in_s, input int exp_s);
        return reg_w(in_s) + exp_s + 2;
    endfunction

endpackage

// File: rtl/posit_pair_buf.sv
// Operand pairing buffer. Holds at most one unmatched operand (A or B) and
// presents a matched pair combinationally on the edge the partner arrives.
// A second operand on the same side before its partner replaces the held
// one and sets the sticky overrun flag.
module posit_pair_buf #(
    parameter int W = 12
) (
    input  logic         clk_i,
    input  logic         rstn,
    input  logic         i_a_vld,
    input  logic [W-1:0] i_a,
    input  logic         i_b_vld,
    input  logic [W-1:0] i_b,
    output logic         o_pair_vld,
    output logic [W-1:0] o_a,
    output logic [W-1:0] o_b,
    output logic         o_err
);

    logic         r_a_hv;
    logic         r_b_hv;
    logic [W-1:0] r_a;
    logic [W-1:0] r_b;
    logic         r_err;

    // Pair selection: a held operand always pairs with the opposite side first
    always_comb begin
        o_pair_vld = 1'b0;
        o_a        = i_a;
        o_b        = i_b;
        if (r_a_hv && i_b_vld) begin
            o_pair_vld = 1'b1;
            o_a        = r_a;
        end else if (r_b_hv && i_a_vld) begin
            o_pair_vld = 1'b1;
            o_b        = r_b;
        end else if (!r_a_hv && !r_b_hv && i_a_vld && i_b_vld) begin
            o_pair_vld = 1'b1;
        end
    end

    // Hold-register update and overrun detection
    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
            r_a_hv <= 1'b0;
            r_b_hv <= 1'b0;
            r_a    <= '0;
            r_b    <= '0;
            r_err  <= 1'b0;
        end else if (r_a_hv) begin
            if (i_b_vld) begin
                // held A consumed; a fresh A (if any) takes its place
                r_a_hv <= i_a_vld;
                if (i_a_vld) r_a <= i_a;
            end else if (i_a_vld) begin
                r_a   <= i_a;
                r_err <= 1'b1;
            end
        end else if (r_b_hv) begin
            if (i_a_vld) begin
                r_b_hv <= i_b_vld;
                if (i_b_vld) r_b <= i_b;
            end else if (i_b_vld) begin
                r_b   <= i_b;
                r_err <= 1'b1;
            end
        end else begin
            if (i_a_vld && !i_b_vld) begin
                r_a_hv <= 1'b1;
                r_a    <= i_a;
            end
            if (i_b_vld && !i_a_vld) begin
                r_b_hv <= 1'b1;
                r_b    <= i_b;
            end
        end
    end

    assign o_err = r_err;

endmodule

// File: rtl/posit_field_mul.sv
// Three-stage multiplier on decoded posit fields (sign, regime, exponent,
// mantissa, type). Produces sign, signed scale, unrounded fraction and type
// for the encoder. Define POSIT_MUL_PAIR_EN to include the operand pairing
// buffer; without it only coincident valids form a pair.
module posit_field_mul
    import posit_pkg::*;
#(
    parameter  int IN_S  = 8,
    parameter  int EXP_S = 2,
    localparam int REG_S = reg_w(IN_S),
    localparam int MTS_S = mts_w(IN_S, EXP_S),
    localparam int SCO_S = sco_w(IN_S, EXP_S)
) (
    input  logic               clk_i,
    input  logic               rstn,
    input  logic               a_sign,
    input  logic [REG_S-1:0]   a_regi,
    input  logic [EXP_S-1:0]   a_exp,
    input  logic [MTS_S-1:0]   a_mts,
    input  logic [1:0]         a_type,
    input  logic               a_vld,
    input  logic               b_sign,
    input  logic [REG_S-1:0]   b_regi,
    input  logic [EXP_S-1:0]   b_exp,
    input  logic [MTS_S-1:0]   b_mts,
    input  logic [1:0]         b_type,
    input  logic               b_vld,
    output logic               sign_o,
    output logic [SCO_S-1:0]   scale_o,
    output logic [2*MTS_S:0]   frac_o,
    output logic [1:0]         type_o,
    output logic               vld_o,
    output logic               err_o
);

    localparam int OPW = 1 + REG_S + EXP_S + MTS_S + 2;
    localparam int SC1 = REG_S + EXP_S;
    localparam int PW  = 2 * MTS_S + 2;

    logic [OPW-1:0] w_a_in, w_b_in, w_a_op, w_b_op;
    logic           w_pair_vld;

    assign w_a_in = {a_sign, a_regi, a_exp, a_mts, a_type};
    assign w_b_in = {b_sign, b_regi, b_exp, b_mts, b_type};

`ifdef POSIT_MUL_PAIR_EN
    posit_pair_buf #(.W(OPW)) u_pair_buf (
        .clk_i      (clk_i),
        .rstn       (rstn),
        .i_a_vld    (a_vld),
        .i_a        (w_a_in),
        .i_b_vld    (b_vld),
        .i_b        (w_b_in),
        .o_pair_vld (w_pair_vld),
        .o_a        (w_a_op),
        .o_b        (w_b_op),
        .o_err      (err_o)
    );
`else
    logic r_err;

    assign w_pair_vld = a_vld & b_vld;
    assign w_a_op     = w_a_in;
    assign w_b_op     = w_b_in;

    // A lone valid has no partner and is dropped; flag it until reset
    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn)              r_err <= 1'b0;
        else if (a_vld ^ b_vld) r_err <= 1'b1;
    end

    assign err_o = r_err;
`endif

    // Unpack the paired operands
    logic             w_a_sign, w_b_sign;
    logic [REG_S-1:0] w_a_regi, w_b_regi;
    logic [EXP_S-1:0] w_a_exp, w_b_exp;
    logic [MTS_S-1:0] w_a_mts, w_b_mts;
    logic [1:0]       w_a_type, w_b_type;

    assign {w_a_sign, w_a_regi, w_a_exp, w_a_mts, w_a_type} = w_a_op;
    assign {w_b_sign, w_b_regi, w_b_exp, w_b_mts, w_b_type} = w_b_op;

    logic [2:0]       r_vld_pipe;
    logic             r1_sign;
    logic [SC1-1:0]   r1_sca_a, r1_sca_b;
    logic [MTS_S:0]   r1_sig_a, r1_sig_b;
    logic [1:0]       r1_type_a, r1_type_b;
    logic             r2_sign;
    logic [PW-1:0]    r2_prod;
    logic [SCO_S-1:0] r2_sum;
    logic [1:0]       r2_type;
    logic             r_sign_o;
    logic [SCO_S-1:0] r_scale_o;
    logic [2*MTS_S:0] r_frac_o;
    logic [1:0]       r_type_o;

    // Valid shift register: [0] stage 1, [1] stage 2, [2] output
    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) r_vld_pipe <= '0;
        else       r_vld_pipe <= {r_vld_pipe[1:0], w_pair_vld};
    end

    // Stage 1: regime*2^es + exp is just {regi, exp}; attach the hidden bit
    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
            r1_sign   <= 1'b0;
            r1_sca_a  <= '0;
            r1_sca_b  <= '0;
            r1_sig_a  <= '0;
            r1_sig_b  <= '0;
            r1_type_a <= POSIT_ZERO;
            r1_type_b <= POSIT_ZERO;
        end else if (w_pair_vld) begin
            r1_sign   <= w_a_sign ^ w_b_sign;
            r1_sca_a  <= {w_a_regi, w_a_exp};
            r1_sca_b  <= {w_b_regi, w_b_exp};
            r1_sig_a  <= {1'b1, w_a_mts};
            r1_sig_b  <= {1'b1, w_b_mts};
            r1_type_a <= w_a_type;
            r1_type_b <= w_b_type;
        end
    end

    logic [PW-1:0]    w_prod;
    logic [SCO_S-1:0] w_sum;
    logic [1:0]       w_type;

    assign w_prod = {{(MTS_S+1){1'b0}}, r1_sig_a} * {{(MTS_S+1){1'b0}}, r1_sig_b};
    assign w_sum  = {{(SCO_S-SC1){r1_sca_a[SC1-1]}}, r1_sca_a}
                  + {{(SCO_S-SC1){r1_sca_b[SC1-1]}}, r1_sca_b};

    // NaR dominates zero, zero dominates valid
    always_comb begin
        w_type = POSIT_VALID;
        if (r1_type_a == POSIT_NAR || r1_type_b == POSIT_NAR)
            w_type = POSIT_NAR;
        else if (r1_type_a == POSIT_ZERO || r1_type_b == POSIT_ZERO)
            w_type = POSIT_ZERO;
    end

    // Stage 2: significand product, scale sum and resolved type
    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
            r2_sign <= 1'b0;
            r2_prod <= '0;
            r2_sum  <= '0;
            r2_type <= POSIT_ZERO;
        end else if (r_vld_pipe[0]) begin
            r2_sign <= r1_sign;
            r2_prod <= w_prod;
            r2_sum  <= w_sum;
            r2_type <= w_type;
        end
    end

    // Stage 3: normalize the product into [1,2) and force special encodings
    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
            r_sign_o  <= 1'b0;
            r_scale_o <= '0;
            r_frac_o  <= '0;
            r_type_o  <= POSIT_ZERO;
        end else if (r_vld_pipe[1]) begin
            r_type_o <= r2_type;
            if (r2_type == POSIT_ZERO) begin
                r_sign_o  <= 1'b0;
                r_scale_o <= '0;
                r_frac_o  <= '0;
            end else if (r2_type == POSIT_NAR) begin
                r_sign_o  <= 1'b1;
                r_scale_o <= '0;
                r_frac_o  <= '0;
            end else if (r2_prod[PW-1]) begin
                r_sign_o  <= r2_sign;
                r_scale_o <= r2_sum + SCO_S'(1);
                r_frac_o  <= r2_prod[2*MTS_S:0];
            end else begin
                r_sign_o  <= r2_sign;
                r_scale_o <= r2_sum;
                r_frac_o  <= {r2_prod[2*MTS_S-1:0], 1'b0};
            end
        end
    end

    assign sign_o  = r_sign_o;
    assign scale_o = r_scale_o;
    assign frac_o  = r_frac_o;
    assign type_o  = r_type_o;
    assign vld_o   = r_vld_pipe[2];

endmodule

// File: doc/posit_field_mul.md
# posit_field_mul

Pipelined multiplier for decoded posit operands. Sits directly downstream of the posit decoders and consumes their field outputs: sign, signed regime, exponent, mantissa, and type code. It pairs one A and one B operand and produces a product in decoded form for the rounding/encoding stage: sign, unbiased signed scale, unrounded fraction, and type.

## Interface
- IN_S, 8: posit width of the operands.
- EXP_S, 2: exponent field width (es).
- REG_S, $clog2(IN_S)+1: signed regime width (derived, localparam).
- MTS_S, IN_S-3-EXP_S: mantissa width (derived, localparam).
- SCO_S, REG_S+EXP_S+2: output scale width (derived, localparam).
- clk_i  in  1  clock.
- rstn  in  1  asynchronous, active-low reset.
- a_sign / b_sign  in  1  operand sign.
- a_regi / b_regi  in  REG_S  two's-complement regime k.
- a_exp / b_exp  in  EXP_S  exponent field.
- a_mts / b_mts  in  MTS_S  fraction bits, hidden 1 implied.
- a_type / b_type  in  2  type code: 00 zero, 01 valid, 10 NaR.
- a_vld / b_vld  in  1  one-cycle qualifier; one pulse per operand.
- sign_o  out  1  product sign.
- scale_o  out  SCO_S  signed product scale.
- frac_o  out  2*MTS_S+1  normalized product fraction, hidden bit removed.
- type_o  out  2  product type.
- vld_o  out  1  one-cycle pulse per product.
- err_o  out  1  sticky operand-overrun flag.

## Operation
- **Pairing buffer.** One hold register per side; at most one side is held at any time.
  - Both valids at the same edge, nothing held: pair the two inputs.
  - A held and b_vld: pair the held A with the incoming B. If a_vld is also high, the new A becomes the hold. B behaves symmetrically.
  - A held, a_vld high, b_vld low: the new A replaces the held A (oldest operand dropped) and err_o is set. B behaves symmetrically.
  - err_o clears only on reset.
- **Stage 1 (pair edge).** Register, per operand:
  - scale = regi·2^EXP_S + exp, with regi sign-extended.
  - significand = {1, mts}.
  - type.
  - sign_p = a_sign ^ b_sign.
- **Stage 2.**
  - P = sig_a × sig_b, width 2·MTS_S+2.
  - Sum of scales, sign-extended to SCO_S.
  - Resolve type: NaR if either operand is NaR; else zero if either is zero; else valid.
- **Stage 3 (output register).**
  - If P[MSB]=1: frac_o = P[2·MTS_S:0] and scale_o = sum+1.
  - Otherwise: frac_o = {P[2·MTS_S-1:0],0} and scale_o = sum.
  - Zero result: sign_o=0, scale_o=0, frac_o=0.
  - NaR result: sign_o=1, scale_o=0, frac_o=0.
- No overflow handling: SCO_S holds the full range. Saturation to maxpos/minpos belongs to the encoder.

## Timing
- Fully pipelined; accepts one pair per cycle.
- The pair forms at edge E. Outputs update at edge E+2, so vld_o is high for the cycle following E+2. Latency is 3 edges counted from and including the pair edge.
- vld_o is high for exactly one cycle per pair. The other outputs hold their last value while vld_o is low.
- Reset values: all outputs 0, type_o=00, err_o=0, hold registers empty, pipeline valid bits 0.
- Reset mid-operation: in-flight products are discarded, with no vld_o after release. Operands presented in the release cycle are sampled normally.

## Configuration
- **POSIT_MUL_PAIR_EN defined:** pairing buffer present, behaving as described under Operation.
- **Not defined:**
  - A pair forms only when a_vld and b_vld coincide.
  - A lone valid is discarded and sets err_o.
  - No hold registers exist.
  - Latency is unchanged.

## Structure
- **Shared package posit_pkg.**
  - Type-code constants: POSIT_ZERO=2'b00, POSIT_VALID=2'b01, POSIT_NAR=2'b10.
  - Width functions for REG_S, MTS_S and SCO_S, so decoder, multiplier and encoder agree.
- **One sub-module: posit_pair_buf.**
  - Holds operands and performs the pairing and overrun logic.
  - Parameterized by operand bundle width; instantiated once.
  - Removed when POSIT_MUL_PAIR_EN is undefined.

## Test plan
All scenarios use IN_S=8, EXP_S=2.
1. **1.0 × 1.0.** Both operands regi=0, exp=0, mts=000, type=01, coincident valids at edge 0 -> vld_o after edge 2; sign_o=0, scale_o=0, frac_o=0000000, type_o=01.
2. **1.5 × 1.5.** Both mts=100 -> P=10010000, scale_o=1, frac_o=0010000. 1.0 × 1.5 with sign_a=1 -> scale_o=0, frac_o=1000000, sign_o=1.
3. **Scale sum.** A regi=-1, exp=3 (scale -1) × B regi=2, exp=1 (scale 9), both mts=000 -> scale_o=8.
4. **Special types.** Zero × NaR -> type_o=10, sign_o=1, scale_o=0, frac_o=0. Zero × valid -> type_o=00, all fields 0.
5. **Pairing and overrun.**
   - a_vld at edge 0, b_vld at edge 3 -> single vld_o after edge 5.
   - a_vld at edges 0 and 1, b_vld at edge 2 -> err_o=1 after edge 1; product uses the edge-1 A.
   - Without the macro, the same stimulus yields no vld_o and err_o=1.
6. **Back-to-back and reset.** Four coincident pairs on consecutive edges -> four consecutive vld_o pulses in order. rstn asserted one cycle after edge 1 -> no further vld_o and all outputs 0.
